// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor_tree_pkg.sv
// Shared definitions for the pipelined wide NOR/OR reduction tree.
//   RADIX     : fan-in of every OR level
//   MODE_*    : encoding of the per-transaction output polarity
//   clog4()   : number of pipeline levels needed for a given width
//   w()       : per-channel output width of level k for a given input width
package gf180mcu_fd_sc_mcu9t5v0__nor_tree_pkg;

  localparam int RADIX = 4;

  localparam logic MODE_NOR = 1'b0;
  localparam logic MODE_OR  = 1'b1;

  // Smallest S with RADIX**S >= width, never less than one level.
  function automatic int clog4(input int width);
    int span;
    int stages;
    span   = 1;
    stages = 0;
    while (span < width) begin
      span   = span * RADIX;
      stages = stages + 1;
    end
    return (stages < 1) ? 1 : stages;
  endfunction

  // ceil(width / RADIX**(k+1)); k = -1 yields the raw input width, which
  // lets the top describe the input of level 0 with the same formula.
  function automatic int w(input int width, input int k);
    int div;
    div = 1;
    for (int i = 0; i <= k; i++) begin
      div = div * RADIX;
    end
    return (width + div - 1) / div;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor_tree_stage.sv
// One level of the reduction tree: ORs each group of RADIX input bits per
// channel (a short last group is padded with zeros), then registers the
// result together with the valid bit and the MODE bit that travel with it.
// The final level folds the output polarity into its data register.
//   CLK, RST   : clock, asynchronous active-high reset
//   en         : load enable from the ready chain
//   in_valid   : valid bit from the previous level (or I_VALID)
//   in_mode    : MODE bit from the previous level (or MODE)
//   in_data    : CHANNELS x IN_W bits, channel c at [c*IN_W +: IN_W]
//   out_valid  : registered valid bit of this level
//   out_mode   : registered MODE bit of this level
//   out_data   : CHANNELS x OUT_W registered OR (or final NOR/OR) bits
module gf180mcu_fd_sc_mcu9t5v0__nor_tree_stage
  import gf180mcu_fd_sc_mcu9t5v0__nor_tree_pkg::*;
#(
  parameter int  IN_W     = 16,
  parameter int  CHANNELS = 2,
  parameter bit  FINAL    = 1'b0,
  localparam int OUT_W    = (IN_W + RADIX - 1) / RADIX
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic                      in_mode,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  output logic                      out_valid,
  output logic                      out_mode,
  output logic [CHANNELS*OUT_W-1:0] out_data
);

  localparam int PAD_W = OUT_W * RADIX;

  logic [PAD_W-1:0]          padded [CHANNELS];
  logic [CHANNELS*OUT_W-1:0] reduced;
  logic [CHANNELS*OUT_W-1:0] data_d;

  // Zero is the OR identity, so padding the short last group is harmless.
  // NOTE: every variable written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      padded[c]           = '0;
      padded[c][IN_W-1:0] = in_data[c*IN_W +: IN_W];
    end
  end

  always_comb begin
    reduced = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int g = 0; g < OUT_W; g++) begin
        reduced[c*OUT_W + g] = |padded[c][g*RADIX +: RADIX];
      end
    end
    // Only the last level applies the polarity; inner levels stay plain OR.
    data_d = (FINAL && (in_mode == MODE_NOR)) ? ~reduced : reduced;
  end

  // NOTE: the data registers are reset too, not just the valid bit, so ZN
  // reads as zero during and right after reset instead of stale data.
  // NOTE: state is updated with non-blocking assignments so every level
  // samples its neighbour's pre-edge value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_mode  <= MODE_NOR;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_data  <= data_d;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe.sv
// Pipelined multi-channel wide NOR/OR reduction with valid/ready handshake.
// Each of CHANNELS WIDTH-bit vectors is reduced through clog4(WIDTH) radix-4
// OR levels, one register per level; the last level applies MODE
// (0 = NOR, 1 = OR). All channels share one valid/ready path.
//   CLK, RST : clock, asynchronous active-high reset
//   A        : operands, channel c at A[c*WIDTH +: WIDTH]
//   MODE     : output polarity, sampled with A
//   I_VALID  : operands valid;  I_READY : block accepts operands
//   ZN       : result bit per channel; O_VALID : ZN valid
//   O_READY  : downstream accepts ZN
module gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe
  import gf180mcu_fd_sc_mcu9t5v0__nor_tree_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS*WIDTH-1:0] A,
  input  logic                      MODE,
  input  logic                      I_VALID,
  output logic                      I_READY,
  output logic [CHANNELS-1:0]       ZN,
  output logic                      O_VALID,
  input  logic                      O_READY
);

  localparam int STAGES = clog4(WIDTH);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] en;

  // Ready chain, walked from the output back to the input: a level may load
  // when it is empty or when the level after it is loading, so bubbles
  // collapse and a full pipeline can drain and fill in the same cycle.
  always_comb begin
    en           = '0;
    en[STAGES-1] = !v_q[STAGES-1] | O_READY;
    for (int k = STAGES - 2; k >= 0; k--) begin
      en[k] = !v_q[k] | en[k+1];
    end
  end

  assign I_READY = en[0] & !RST;

  for (genvar k = 0; k < STAGES; k++) begin : gen_lvl
    localparam int IN_W  = w(WIDTH, k - 1);
    localparam int OUT_W = w(WIDTH, k);

    logic [CHANNELS*IN_W-1:0]  in_data;
    logic                      in_valid;
    logic                      in_mode;
    logic [CHANNELS*OUT_W-1:0] data_q;
    logic                      valid_q;
    logic                      mode_q;

    if (k == 0) begin : g_head
      assign in_data  = A;
      assign in_valid = I_VALID;
      assign in_mode  = MODE;
    end else begin : g_body
      assign in_data  = gen_lvl[k-1].data_q;
      assign in_valid = gen_lvl[k-1].valid_q;
      assign in_mode  = gen_lvl[k-1].mode_q;
    end

    gf180mcu_fd_sc_mcu9t5v0__nor_tree_stage #(
      .IN_W     (IN_W),
      .CHANNELS (CHANNELS),
      .FINAL    (k == STAGES - 1)
    ) u_stage (
      .CLK       (CLK),
      .RST       (RST),
      .en        (en[k]),
      .in_valid  (in_valid),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (valid_q),
      .out_mode  (mode_q),
      .out_data  (data_q)
    );

    assign v_q[k] = valid_q;
  end

  // The last level's width is always one bit per channel.
  assign ZN      = gen_lvl[STAGES-1].data_q;
  assign O_VALID = v_q[STAGES-1];

  // The last MODE register has already been folded into ZN; nothing reads it.
  logic unused_last_mode;
  assign unused_last_mode = gen_lvl[STAGES-1].mode_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe.md
# gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe

Parametrised, pipelined, multi-channel wide NOR/OR reduction with valid/ready flow control. It is the sequential successor to the fixed two-input NOR cell. It reduces CHANNELS independent WIDTH-bit vectors through radix-4 OR levels, with one register per level. The final level applies a per-transaction output polarity. It sits between wide status/flag buses and downstream control logic where a single-cycle wide NOR would not meet timing.

## Interface
- WIDTH, 16, bits reduced per channel; legal 2..256
- CHANNELS, 2, independent reduction channels; legal 1..16
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- A  input  CHANNELS*WIDTH  operand vectors; channel c occupies A[c*WIDTH +: WIDTH]
- MODE  input  1  0 = NOR result, 1 = OR result; sampled with the operands
- I_VALID  input  1  operands and MODE valid this cycle
- I_READY  output  1  block accepts operands this cycle
- ZN  output  CHANNELS  reduction result, bit c for channel c
- O_VALID  output  1  ZN valid
- O_READY  input  1  downstream accepts ZN this cycle

## Operation
- Stage count: S = ceil(log4(WIDTH)), minimum 1. Examples: WIDTH=4 gives S=1, 16 gives 2, 17 gives 3, 256 gives 4.
- Level k (0..S-1) ORs groups of 4 bits from level k-1 (level 0 uses A). A short final group is padded with 0, the OR identity.
- Each level holds a valid bit v[k], a data register per channel, and a MODE bit that travels with the data.
- The last level writes ZN[c] = MODE ? OR(A_c) : ~OR(A_c). Intermediate levels always compute the plain OR.
- Per-level advance: en[S-1] = !v[S-1] | O_READY; en[k] = !v[k] | en[k+1]. Bubbles collapse, so an empty level always accepts.
- When en[k] is high, level k loads the previous level's data and valid. Otherwise it holds.
- I_READY = en[0] & !RST. A transfer happens when I_VALID & I_READY.
- O_VALID = v[S-1], and ZN is the data register of the last level. Both are held stable while O_VALID & !O_READY.
- Channels share one valid/ready path. No per-channel flow control.
- Reset (asynchronous assert): all v[k] = 0, all data registers = 0, MODE registers = 0.
  - Outputs during and after reset: O_VALID = 0, ZN = 0, I_READY = 0 while RST is high.
  - Reset mid-operation discards all in-flight transactions with no partial output.
  - I_READY = 1 in the first cycle after RST is released.
- Reset release must be synchronised externally to CLK. The block does not synchronise deassertion.

## Timing
- Latency: a transaction accepted at edge n gives O_VALID = 1 after edge n+S-1. ZN is first observable in cycle n+S-1.
- Throughput: one transaction per cycle while O_READY is held high.
- Capacity: S transactions in flight. With O_READY low, I_READY drops after the pipeline fills, exactly S accepts after the last drain.
- Simultaneous drain and fill in the same cycle while full is allowed. I_READY stays high because the ready chain is combinational.
- The combinational path O_READY to I_READY passes through S AND/OR levels. This is acceptable for S ≤ 4.
- Timing arcs are declared from CLK to ZN and CLK to O_VALID. There is no combinational arc from A to ZN.

## Structure
- Shared package gf180mcu_fd_sc_mcu9t5v0__nor_tree_pkg holds:
  - RADIX = 4 constant
  - clog4 function for the stage count
  - MODE encoding constants MODE_NOR = 0, MODE_OR = 1
  - per-level width function w(k) = ceil(WIDTH / 4^(k+1))
- Sub-module gf180mcu_fd_sc_mcu9t5v0__nor_tree_stage implements one level: radix-4 OR with zero padding, valid/data/MODE registers, load enable, and a final-stage inversion parameter. The top module generates S instances and the ready chain.

## Test plan
- Reset: assert RST with the pipeline full -> O_VALID=0, ZN=0, I_READY=0 during reset; I_READY=1 on the first cycle after release; no stale output appears afterwards.
- Basic NOR, WIDTH=16, CHANNELS=2, MODE=0: A = 32'h0000_0000 -> ZN=2'b11 two cycles after accept; A = 32'h0001_0000 -> ZN=2'b01 (channel 1 nonzero gives 0).
- OR mode with padding, WIDTH=17: MODE=1, A = 17'h10000 -> ZN=1 after 3 cycles; A = 0 -> ZN=0.
- Streaming: 8 back-to-back transactions with O_READY=1 -> 8 consecutive O_VALID cycles, results in order, and each MODE matches its own transaction.
- Backpressure, WIDTH=16: O_READY=0 -> exactly 2 transactions accepted, then I_READY=0 and ZN/O_VALID hold stable. When O_READY returns to 1, outputs drain in order with no loss or duplication.
- Random stall: random I_VALID/O_READY over 10k cycles, WIDTH=256, CHANNELS=16 -> scoreboard match against a reference NOR/OR model. No accepted transaction is dropped.
